// File: rtl/cordic_dds_pkg.sv
// Shared constants and elaboration-time helpers for the CORDIC DDS pipeline.
//   atan_angle : rotation angle of one CORDIC stage, in residue units where
//                2^(pw+2) counts = 360 deg
//   x0_init    : gain-compensated starting x so the rotated vector lands on
//                full scale 2^(dw-1)-1
//   latency    : cycles from an I_en sample to its O_valid
package cordic_dds_pkg;

    // atan(2^-idx) with 2^32 counts per full turn. Past the table the angle is
    // close enough to 2^-idx rad that a plain shift of 2^32/(2*pi) is used.
    function automatic logic [31:0] atan_full(input int idx);
        logic [31:0] a;
        case (idx)
            0:       a = 32'd536870912;
            1:       a = 32'd316933406;
            2:       a = 32'd167458907;
            3:       a = 32'd85004756;
            4:       a = 32'd42667331;
            5:       a = 32'd21354465;
            6:       a = 32'd10679838;
            7:       a = 32'd5340245;
            8:       a = 32'd2670163;
            9:       a = 32'd1335087;
            10:      a = 32'd667544;
            11:      a = 32'd333772;
            12:      a = 32'd166886;
            13:      a = 32'd83443;
            14:      a = 32'd41722;
            15:      a = 32'd20861;
            16:      a = 32'd10430;
            17:      a = 32'd5215;
            18:      a = 32'd2608;
            19:      a = 32'd1304;
            20:      a = 32'd652;
            21:      a = 32'd326;
            22:      a = 32'd163;
            23:      a = 32'd81;
            default: a = 32'd683565276 >> idx;
        endcase
        return a;
    endfunction

    // Rescale the 32-bit turn fraction to pw+2 bits with round-to-nearest.
    function automatic logic [31:0] atan_angle(input int idx, input int pw);
        int sh;
        sh = 30 - pw;
        return (atan_full(idx) + (32'd1 << (sh - 1))) >> sh;
    endfunction

    // round(0.607253 * (2^(dw-1)-1)); 2608131775 is 0.607253 * 2^32.
    function automatic logic [31:0] x0_init(input int dw);
        logic [63:0] prod;
        prod = ((64'd1 << (dw - 1)) - 64'd1) * 64'd2608131775 + 64'h8000_0000;
        return prod[63:32];
    endfunction

    // Phase register, quadrant fold, NSTAGE rotations, output register.
    function automatic int latency(input int nstage);
        return nstage + 3;
    endfunction

endpackage

// File: rtl/cordic_dds_pipe_stage.sv
// One registered CORDIC rotation (module cordic_stage).
//   clk, rst_n       : clock, async active-low reset
//   x_in/y_in/z_in   : vector and remaining angle from the previous stage
//   neg_in           : quadrant-fold negate flag, passed through untouched
//   x_out/.../neg_out: registered results for the next stage
module cordic_stage
    import cordic_dds_pkg::*;
#(
    parameter int XW  = 16,
    parameter int ZW  = 18,
    parameter int IDX = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic signed [XW-1:0] x_in,
    input  logic signed [XW-1:0] y_in,
    input  logic signed [ZW-1:0] z_in,
    input  logic                 neg_in,
    output logic signed [XW-1:0] x_out,
    output logic signed [XW-1:0] y_out,
    output logic signed [ZW-1:0] z_out,
    output logic                 neg_out
);

    localparam logic [31:0]        ANGLE_FULL = atan_angle(IDX, ZW - 2);
    localparam logic signed [ZW-1:0] ANGLE    = ANGLE_FULL[ZW-1:0];
    // Half an LSB of the shifted value, so the shift rounds instead of
    // flooring; truncation bias would otherwise accumulate over the stages.
    localparam int RND = (1 << IDX) >> 1;

    logic signed [XW-1:0] x_shift, y_shift;
    logic signed [XW-1:0] x_d, y_d, x_q, y_q;
    logic signed [ZW-1:0] z_d, z_q;
    logic                 neg_d, neg_q;

    // Rotate toward zero residual angle: positive residue turns counter-clockwise.
    always_comb begin
        x_shift = (x_in + XW'(RND)) >>> IDX;
        y_shift = (y_in + XW'(RND)) >>> IDX;
        neg_d   = neg_in;
        if (!z_in[ZW-1]) begin
            x_d = x_in - y_shift;
            y_d = y_in + x_shift;
            z_d = z_in - ANGLE;
        end else begin
            x_d = x_in + y_shift;
            y_d = y_in - x_shift;
            z_d = z_in + ANGLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q   <= '0;
            y_q   <= '0;
            z_q   <= '0;
            neg_q <= 1'b0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            z_q   <= z_d;
            neg_q <= neg_d;
        end
    end

    assign x_out   = x_q;
    assign y_out   = y_q;
    assign z_out   = z_q;
    assign neg_out = neg_q;

endmodule

// File: rtl/cordic_dds_pipe.sv
// Pipelined CORDIC direct digital synthesiser producing cos/sin samples.
//   I_clk, I_rst_n        : clock, async active-low reset
//   I_en                  : advance the accumulator and launch one sample
//   I_load                : load I_init_phase / I_inc_phase
//   I_init_phase          : accumulator value on load
//   I_inc_phase           : unsigned phase step
//   I_offset              : phase offset added to each launched sample
//   O_cos, O_sin, O_valid : saturated samples, valid pulse per sample
module cordic_dds_pipe
    import cordic_dds_pkg::*;
#(
    parameter int DW     = 14,
    parameter int PW     = 16,
    parameter int NSTAGE = 14
) (
    input  logic                 I_clk,
    input  logic                 I_rst_n,
    input  logic                 I_en,
    input  logic                 I_load,
    input  logic [PW-1:0]        I_init_phase,
    input  logic [PW-1:0]        I_inc_phase,
    input  logic [PW-1:0]        I_offset,
    output logic signed [DW-1:0] O_cos,
    output logic signed [DW-1:0] O_sin,
    output logic                 O_valid
);

    localparam int XW = DW + 2;
    localparam int ZW = PW + 2;
    localparam int L  = latency(NSTAGE);

    localparam logic [31:0]          X0_FULL = x0_init(DW);
    localparam logic signed [XW-1:0] X0      = X0_FULL[XW-1:0];
    localparam logic signed [XW-1:0] MAX_MAG = XW'((1 << (DW - 1)) - 1);
    localparam logic signed [XW-1:0] MIN_MAG = -MAX_MAG;

    logic [PW-1:0]        acc_d, acc_q, inc_d, inc_q, phase_d, phase_q;
    logic [PW-1:0]        folded;
    logic signed [ZW-1:0] fold_z_d, fold_z_q;
    logic                 fold_neg_d, fold_neg_q;
    logic [L-1:0]         valid_d, valid_q;
    logic signed [XW-1:0] cos_full, sin_full;
    logic signed [DW-1:0] cos_d, cos_q, sin_d, sin_q;

    logic signed [XW-1:0] x_pipe   [0:NSTAGE];
    logic signed [XW-1:0] y_pipe   [0:NSTAGE];
    logic signed [ZW-1:0] z_pipe   [0:NSTAGE];
    logic                 neg_pipe [0:NSTAGE];

    // The launched phase is the accumulator's next value, so a load together
    // with an enable launches the loaded phase itself.
    always_comb begin
        acc_d = acc_q;
        inc_d = inc_q;
        if (I_load) begin
            acc_d = I_init_phase;
            inc_d = I_inc_phase;
        end else if (I_en) begin
            acc_d = acc_q + inc_q;
        end
        phase_d = acc_d + I_offset;
    end

    // Quadrants 90..270 deg are moved by 180 deg (flip of the MSB) into the
    // CORDIC convergence range; the result is negated at the output instead.
    // Appending two zero bits gives the residue its guard bits.
    always_comb begin
        fold_neg_d = phase_q[PW-1] ^ phase_q[PW-2];
        folded     = {phase_q[PW-1] ^ fold_neg_d, phase_q[PW-2:0]};
        fold_z_d   = {folded, 2'b00};
        valid_d    = {valid_q[L-2:0], I_en};
    end

    assign x_pipe[0]   = X0;
    assign y_pipe[0]   = '0;
    assign z_pipe[0]   = fold_z_q;
    assign neg_pipe[0] = fold_neg_q;

    for (genvar i = 0; i < NSTAGE; i++) begin : g_stage
        cordic_stage #(
            .XW  (XW),
            .ZW  (ZW),
            .IDX (i)
        ) u_stage (
            .clk     (I_clk),
            .rst_n   (I_rst_n),
            .x_in    (x_pipe[i]),
            .y_in    (y_pipe[i]),
            .z_in    (z_pipe[i]),
            .neg_in  (neg_pipe[i]),
            .x_out   (x_pipe[i+1]),
            .y_out   (y_pipe[i+1]),
            .z_out   (z_pipe[i+1]),
            .neg_out (neg_pipe[i+1])
        );
    end

    // Symmetric clamp keeps -2^(DW-1) out of the output range.
    function automatic logic signed [DW-1:0] clamp(input logic signed [XW-1:0] v);
        if (v > MAX_MAG)
            return MAX_MAG[DW-1:0];
        else if (v < MIN_MAG)
            return MIN_MAG[DW-1:0];
        else
            return v[DW-1:0];
    endfunction

    // Output registers only move when a launched sample arrives, so they hold
    // the last sample across gaps.
    always_comb begin
        cos_full = neg_pipe[NSTAGE] ? -x_pipe[NSTAGE] : x_pipe[NSTAGE];
        sin_full = neg_pipe[NSTAGE] ? -y_pipe[NSTAGE] : y_pipe[NSTAGE];
        cos_d    = cos_q;
        sin_d    = sin_q;
        if (valid_q[L-2]) begin
            cos_d = clamp(cos_full);
            sin_d = clamp(sin_full);
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            acc_q      <= '0;
            inc_q      <= '0;
            phase_q    <= '0;
            fold_z_q   <= '0;
            fold_neg_q <= 1'b0;
            valid_q    <= '0;
            cos_q      <= '0;
            sin_q      <= '0;
        end else begin
            acc_q      <= acc_d;
            inc_q      <= inc_d;
            phase_q    <= phase_d;
            fold_z_q   <= fold_z_d;
            fold_neg_q <= fold_neg_d;
            valid_q    <= valid_d;
            cos_q      <= cos_d;
            sin_q      <= sin_d;
        end
    end

    assign O_cos   = cos_q;
    assign O_sin   = sin_q;
    assign O_valid = valid_q[L-1];

endmodule

// File: tb/tb_cordic_dds_pipe.sv
// Self-checking bench for cordic_dds_pipe: directed phase patterns plus
// randomized enable/load/offset traffic, compared against an ideal
// trigonometric reference with a fixed sample delay.
module tb_cordic_dds_pipe;

    localparam int    DW     = 14;
    localparam int    PW     = 16;
    localparam int    NSTAGE = 14;
    localparam int    LAT    = NSTAGE + 3;
    localparam real   AMP    = 8191.0;
    localparam real   PI     = 3.14159265358979323846;
    localparam int    TOL    = 3;

    logic                 I_clk = 1'b0;
    logic                 I_rst_n = 1'b1;
    logic                 I_en = 1'b0;
    logic                 I_load = 1'b0;
    logic [PW-1:0]        I_init_phase = '0;
    logic [PW-1:0]        I_inc_phase = '0;
    logic [PW-1:0]        I_offset = '0;
    logic signed [DW-1:0] O_cos;
    logic signed [DW-1:0] O_sin;
    logic                 O_valid;

    cordic_dds_pipe #(
        .DW     (DW),
        .PW     (PW),
        .NSTAGE (NSTAGE)
    ) dut (
        .I_clk        (I_clk),
        .I_rst_n      (I_rst_n),
        .I_en         (I_en),
        .I_load       (I_load),
        .I_init_phase (I_init_phase),
        .I_inc_phase  (I_inc_phase),
        .I_offset     (I_offset),
        .O_cos        (O_cos),
        .O_sin        (O_sin),
        .O_valid      (O_valid)
    );

    always #5 I_clk = ~I_clk;

    // Reference model: every clock edge enters one slot into a delay line of
    // LAT slots; a slot carrying a launch becomes the expected sample.
    typedef struct packed {
        logic          en;
        logic [PW-1:0] ph;
    } slot_t;

    slot_t         delayLine[$];
    logic [PW-1:0] modelAcc = '0;
    logic [PW-1:0] modelInc = '0;
    int            expValid = 0;
    int            expCos = 0;
    int            expSin = 0;
    int            errors = 0;
    int            checks = 0;

    function automatic int idealCos(input logic [PW-1:0] ph);
        real ang;
        ang = 2.0 * PI * real'(ph) / 65536.0;
        return $rtoi($floor(AMP * $cos(ang) + 0.5));
    endfunction

    function automatic int idealSin(input logic [PW-1:0] ph);
        real ang;
        ang = 2.0 * PI * real'(ph) / 65536.0;
        return $rtoi($floor(AMP * $sin(ang) + 0.5));
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected, input int tol);
        int diff;
        checks++;
        diff = observed - expected;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, want %0d (+/-%0d) at %0t", tag, observed, expected, tol, $time);
        end
    endtask

    // One clock of stimulus: drive on the falling edge, advance the model on
    // the rising edge, then compare shortly after it.
    task automatic applyStimulus(input logic en, input logic load, input logic [PW-1:0] initPh,
                                 input logic [PW-1:0] incPh, input logic [PW-1:0] offPh);
        slot_t s;
        @(negedge I_clk);
        I_en         = en;
        I_load       = load;
        I_init_phase = initPh;
        I_inc_phase  = incPh;
        I_offset     = offPh;
        @(posedge I_clk);
        if (load) begin
            modelAcc = initPh;
            modelInc = incPh;
        end else if (en) begin
            modelAcc = modelAcc + modelInc;
        end
        s.en = en;
        s.ph = modelAcc + offPh;
        delayLine.push_back(s);
        expValid = 0;
        if (delayLine.size() == LAT) begin
            s = delayLine.pop_front();
            if (s.en) begin
                expValid = 1;
                expCos   = idealCos(s.ph);
                expSin   = idealSin(s.ph);
            end
        end
        #1;
        checkOutput("valid", int'(O_valid), expValid, 0);
        checkOutput("cos", int'(O_cos), expCos, TOL);
        checkOutput("sin", int'(O_sin), expSin, TOL);
    endtask

    // Pull reset low between edges and confirm outputs clear without a clock.
    task automatic pulseReset();
        #2;
        I_rst_n = 1'b0;
        I_en    = 1'b0;
        I_load  = 1'b0;
        #1;
        checkOutput("rst_valid", int'(O_valid), 0, 0);
        checkOutput("rst_cos", int'(O_cos), 0, 0);
        checkOutput("rst_sin", int'(O_sin), 0, 0);
        delayLine.delete();
        modelAcc = '0;
        modelInc = '0;
        expCos   = 0;
        expSin   = 0;
        repeat (2) @(negedge I_clk);
        I_rst_n = 1'b1;
    endtask

    task automatic randomTraffic(input int cycles);
        logic [PW-1:0] off;
        off = '0;
        for (int i = 0; i < cycles; i++) begin
            if ($urandom_range(0, 3) == 0) off = PW'($urandom());
            applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0,
                          PW'($urandom()), PW'($urandom()), off);
        end
    endtask

    initial begin
        pulseReset();

        // Fixed phase 0, then 90 and 180 degrees.
        applyStimulus(1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000);
        repeat (20) applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000);
        applyStimulus(1'b1, 1'b1, 16'h4000, 16'h0000, 16'h0000);
        repeat (20) applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000);
        applyStimulus(1'b1, 1'b1, 16'h8000, 16'h0000, 16'h0000);
        repeat (20) applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000);

        // 16-sample period, sustained one sample per cycle.
        applyStimulus(1'b1, 1'b1, 16'h0000, 16'h1000, 16'h0000);
        repeat (40) applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000);

        // Accumulator wrap through zero.
        applyStimulus(1'b1, 1'b1, 16'hFFF0, 16'h0020, 16'h0000);
        repeat (25) applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000);

        // Alternating enable with a 90 degree offset.
        for (int i = 0; i < 40; i++)
            applyStimulus((i % 2) == 0, i == 0, 16'h0000, 16'h0400, 16'h4000);
        repeat (LAT) applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h4000);

        randomTraffic(200);

        // Reset in the middle of a busy stream, then resume after a gap.
        pulseReset();
        repeat (5) applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
        applyStimulus(1'b1, 1'b1, 16'h2000, 16'h0300, 16'h0000);
        repeat (25) applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000);

        randomTraffic(200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cordic_dds_pipe.md
CORDIC_DDS_PIPE -- requirements
Module: cordic_dds_pipe

Interface
REQ-001 SHALL have parameter DW, default 14, output sample width (signed two's complement).
REQ-002 SHALL have parameter PW, default 16, phase word width; 2^PW counts = 360 deg.
REQ-003 SHALL have parameter NSTAGE, default 14, CORDIC iteration count, legal range 8..DW+2.
REQ-004 I_clk  in  1  single clock; all state on rising edge.
REQ-005 I_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 I_en  in  1  advance accumulator and launch one sample this cycle.
REQ-007 I_load  in  1  load I_init_phase and I_inc_phase this cycle.
REQ-008 I_init_phase  in  PW  accumulator value written on I_load.
REQ-009 I_inc_phase  in  PW  phase step, unsigned, written on I_load.
REQ-010 I_offset  in  PW  phase offset added to accumulator output, sampled every launch.
REQ-011 O_cos  out  DW  cosine sample.
REQ-012 O_sin  out  DW  sine sample.
REQ-013 O_valid  out  1  O_cos/O_sin hold a new sample this cycle.

Function
REQ-014 Accumulator SHALL update: I_load -> acc=I_init_phase, inc=I_inc_phase; else I_en -> acc=acc+inc mod 2^PW; else hold.
REQ-015 Simultaneous I_load and I_en SHALL load and launch a sample at I_init_phase (new value, not old acc+inc).
REQ-016 Launched phase SHALL be (acc or loaded value) + I_offset mod 2^PW, registered in stage 0.
REQ-017 Quadrant fold: phase top two bits 01/10 (90..270 deg) SHALL subtract 2^(PW-1) and set a negate flag carried down the pipeline.
REQ-018 Rotation stage i SHALL use angle atan(2^-i) scaled to PW+2 bits, x0=round(0.607253*(2^(DW-1)-1)), y0=0; one stage per register.
REQ-019 Internal x/y width SHALL be DW+2; angle residue width PW+2; shifts arithmetic.
REQ-020 Output stage SHALL apply negate flag, then saturate to +/-(2^(DW-1)-1); -2^(DW-1) never emitted.
REQ-021 Latency SHALL be L=NSTAGE+3 cycles from I_en sample to O_valid, fixed, independent of I_en gaps.
REQ-022 O_valid SHALL be I_en delayed L cycles via shift register; O_cos/O_sin hold last value when O_valid=0.
REQ-023 I_load mid-stream SHALL not disturb samples already in flight; first new-phase sample emerges L cycles after load.
REQ-024 Accuracy: |error| <= 3 LSB vs ideal (2^(DW-1)-1)*cos/sin for DW=14, NSTAGE=14.
REQ-025 Fully pipelined: one sample per cycle sustained with I_en held high.

Reset
REQ-026 I_rst_n low SHALL immediately clear acc, inc, all pipeline registers, valid shift register; O_cos=0, O_sin=0, O_valid=0.
REQ-027 Reset mid-operation SHALL discard in-flight samples; after release O_valid stays 0 until L cycles after first I_en.

Structure
REQ-028 Package cordic_dds_pkg SHALL hold atan table function (angle per stage, PW+2 bits), gain-compensated x0 function of DW, latency constant function L(NSTAGE).
REQ-029 One sub-module cordic_stage SHALL implement a single registered rotation, parametrised by stage index, instantiated NSTAGE times via generate.

Verification
REQ-030 Load init=0, inc=0, I_en=1 -> after 17 cycles O_valid=1, O_cos=8191+/-3, O_sin=0+/-3.
REQ-031 Load init=0x4000 (90 deg) -> O_cos=0+/-3, O_sin=8191+/-3; init=0x8000 -> O_cos=-8191+/-3, O_sin=0+/-3.
REQ-032 inc=0x1000 continuous -> period 16 samples, every sample within +/-3 LSB of ideal, O_valid continuously high.
REQ-033 init=0xFFF0, inc=0x0020 -> accumulator wraps to 0x0010, output phase continuous, no glitch.
REQ-034 I_en toggled 1010..., offset=0x4000 -> O_valid same pattern delayed 17 cycles, samples equal cos shifted 90 deg.
REQ-035 Assert I_rst_n low mid-stream -> O_valid, O_cos, O_sin 0 immediately (before next edge); first valid 17 cycles after I_en resumes.
